rob_commit: RTL and testbench
=============================

# rob_commit

Eight-entry reorder buffer and in-order commit stage for the Tomasulo core. The issue stage allocates a tail entry per decoded instruction; execution units write results back by ROB tag over the common data bus. The block retires completed entries from the head one per cycle, driving register-bank writes, memory stores, and the mispredict flush.

## Interface
- DEPTH, 8: ROB entries; pointers are log2(DEPTH) = 3 bits and wrap modulo DEPTH.
- DW, 16: result data width.
- clk1  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  issue presents an instruction.
- alloc_func  in  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 load, 0101 store, 0110 beq, 0111 bneq.
- alloc_rd  in  4  destination register; ignored for store and branches.
- alloc_ready  out  1  combinational; entry can be accepted this cycle.
- alloc_tag  out  3  combinational; equals tail pointer, the tag assigned on accept.
- wb_valid  in  1  CDB writeback strobe.
- wb_tag  in  3  ROB entry being completed.
- wb_data  in  DW  result, or store data.
- wb_addr  in  8  store address; don't-care otherwise.
- wb_taken  in  1  branch outcome; 1 means mispredicted/taken, requires flush.
- commit_valid  out  1  registered; one entry retired this cycle.
- commit_tag  out  3  tag of the retired entry; regbank clears its ROB field if it matches.
- commit_wen  out  1  registered; register write for funcs 0000–0100.
- commit_rd  out  4  destination register.
- commit_data  out  DW  value to write.
- commit_mem_we  out  1  registered; store commit for func 0101.
- commit_addr  out  8  store address.
- flush  out  1  registered one-cycle pulse; a taken branch retired.

## Operation
- Per-entry state: valid, done, func, rd, data, addr, taken. Also head, tail (3 bits) and count (0..8).
- Accept: alloc_valid && alloc_ready. On accept, the tail entry is written with valid=1, done=0, func, rd; tail is incremented mod 8.
- alloc_ready = (count < 8) && !flush_now. flush_now = head entry is valid, done, a branch, and taken.
- Writeback: wb_valid to a valid entry sets done=1 and captures data, addr and taken. Writeback to an invalid tag is ignored. A second writeback to the same done entry overwrites it.
- Commit: when the head entry is valid and done, retire it. This drives the commit_* registers for one cycle, clears valid, and increments head.
  - Arithmetic/load: commit_wen=1.
  - Store: commit_mem_we=1, commit_addr=addr, commit_data=data.
  - Branch: no write. If taken, flush=1.
- Flush: on retiring a taken branch, all entries are cleared, tail is set to the new head, and count is set to 0. Any allocation is blocked that cycle because alloc_ready is 0.
- Count update: +1 on accept, −1 on commit, unchanged when both occur.
- Not-taken branches retire as no-ops.

## Timing
- Reset: head=tail=count=0, all valid/done cleared. All commit_* outputs and flush are 0. alloc_ready=1, alloc_tag=0.
- Latency:
  - A writeback at edge N to the head entry produces commit_valid after edge N+1.
  - A writeback to an entry behind an incomplete head waits for in-order retirement.
  - Minimum issue-to-commit is 2 edges: accept, then writeback, then commit.
- Throughput: 1 accept and 1 commit per cycle, sustained.
- commit_* outputs and flush are high for exactly one cycle per retirement. When nothing retires, commit_valid, commit_wen, commit_mem_we and flush return to 0. Data outputs hold their last values.
- Full (count=8): alloc_ready=0 even if a commit occurs the same cycle; there is no bypass.
- Empty: nothing commits. A writeback and an allocation to the same tag in the same cycle cannot occur, because the tag is not yet issued.
- Writeback at the same edge as allocation of a different entry: both take effect.
- Pointer wrap 7→0 is seamless.
- rst asserted mid-operation: all entries are discarded on that edge, with no commit or flush.

## Test plan
- Reset, then allocate add rd=3 (tag 0), wb tag0 data=0x00AB → next cycle: commit_valid=1, commit_wen=1, commit_rd=3, commit_data=0x00AB, commit_tag=0.
- Allocate tags 0,1,2. Write back 2, then 1, then 0 → commits occur in order 0,1,2 on consecutive cycles after tag 0 completes.
- Allocate 8 entries → alloc_ready=0 at count=8. Retire one → alloc_ready=1, alloc_tag=0 (wrap).
- Allocate store (tag0). wb data=0x1234, addr=0x40 → commit_mem_we=1, commit_addr=0x40, commit_data=0x1234, commit_wen=0.
- Allocate beq (tag0) and add (tag1). wb tag1, then wb tag0 taken=1 → flush=1 with commit_tag=0. The add never commits, count=0, and the next alloc_tag is 1.
- Assert rst with 4 live entries → commit_valid stays 0, alloc_ready=1, alloc_tag=0.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: eight-entry reorder buffer with in-order commit.
//
// The issue stage allocates the tail entry for each decoded instruction.
// Execution units complete entries by tag over the CDB. The head entry
// retires when it is complete, at most one entry per cycle. Retirement
// drives a register write, a memory store, or a mispredict flush.
//
// Handshake: an allocation is accepted on a rising edge of clk1 when
// alloc_valid and alloc_ready are both high. alloc_tag is the tag given to
// that instruction. A CDB writeback (wb_valid) has no ready; it is taken on
// the edge where it is presented, and it is dropped if its tag is not live.
//
// Ports:
//   clk1, rst          clock; synchronous active-high reset
//   alloc_valid/func/rd  issue request (opcode, destination register)
//   alloc_ready/tag    combinational accept indication and the assigned tag
//   wb_valid/tag/data/addr/taken  CDB writeback by ROB tag
//   commit_valid/tag   registered retirement strobe and the retired tag
//   commit_wen/rd/data register-bank write (add, sub, mul, div, load)
//   commit_mem_we/addr memory store (store data on commit_data)
//   flush              registered pulse when a taken branch retires
module rob_commit #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic                       clk1,
  input  logic                       rst,
  input  logic                       alloc_valid,
  input  logic [3:0]                 alloc_func,
  input  logic [3:0]                 alloc_rd,
  output logic                       alloc_ready,
  output logic [$clog2(DEPTH)-1:0]   alloc_tag,
  input  logic                       wb_valid,
  input  logic [$clog2(DEPTH)-1:0]   wb_tag,
  input  logic [DW-1:0]              wb_data,
  input  logic [7:0]                 wb_addr,
  input  logic                       wb_taken,
  output logic                       commit_valid,
  output logic [$clog2(DEPTH)-1:0]   commit_tag,
  output logic                       commit_wen,
  output logic [3:0]                 commit_rd,
  output logic [DW-1:0]              commit_data,
  output logic                       commit_mem_we,
  output logic [7:0]                 commit_addr,
  output logic                       flush
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0] F_LOAD  = 4'b0100;
  localparam logic [3:0] F_STORE = 4'b0101;
  localparam logic [3:0] F_BEQ   = 4'b0110;
  localparam logic [3:0] F_BNEQ  = 4'b0111;

  // Entry control bits (reset) and payload (not reset; only read when valid).
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] taken_q, taken_d;
  logic [3:0]       func_q [DEPTH];
  logic [3:0]       func_d [DEPTH];
  logic [3:0]       rd_q   [DEPTH];
  logic [3:0]       rd_d   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [7:0]       addr_q [DEPTH];
  logic [7:0]       addr_d [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic          commit_valid_q, commit_valid_d;
  logic [AW-1:0] commit_tag_q, commit_tag_d;
  logic          commit_wen_q, commit_wen_d;
  logic [3:0]    commit_rd_q, commit_rd_d;
  logic [DW-1:0] commit_data_q, commit_data_d;
  logic          commit_mem_we_q, commit_mem_we_d;
  logic [7:0]    commit_addr_q, commit_addr_d;
  logic          flush_q, flush_d;

  logic [3:0] head_func;
  logic       commit_now;
  logic       head_is_br;
  logic       flush_now;
  logic       accept;

  always_comb begin
    head_func  = func_q[head_q];
    commit_now = valid_q[head_q] && done_q[head_q];
    head_is_br = (head_func == F_BEQ) || (head_func == F_BNEQ);
    flush_now  = commit_now && head_is_br && taken_q[head_q];
  end

  // No bypass: a full ROB refuses allocation even while the head retires.
  assign alloc_ready = (count_q < FULL_CNT) && !flush_now;
  assign alloc_tag   = tail_q;
  assign accept      = alloc_valid && alloc_ready;

  // Entry array, pointers and occupancy.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    taken_d = taken_q;
    func_d  = func_q;
    rd_d    = rd_q;
    data_d  = data_q;
    addr_d  = addr_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // Writebacks to non-live tags are dropped; repeats overwrite.
    if (wb_valid && valid_q[wb_tag]) begin
      done_d[wb_tag]  = 1'b1;
      data_d[wb_tag]  = wb_data;
      addr_d[wb_tag]  = wb_addr;
      taken_d[wb_tag] = wb_taken;
    end

    if (commit_now) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + AW'(1);
    end

    if (flush_now) begin
      // Everything younger than the branch is discarded; the ROB restarts
      // empty at the entry after the branch. Allocation is blocked here.
      valid_d = '0;
      done_d  = '0;
      tail_d  = head_q + AW'(1);
      count_d = '0;
    end else begin
      if (accept) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        func_d[tail_q]  = alloc_func;
        rd_d[tail_q]    = alloc_rd;
        tail_d          = tail_q + AW'(1);
      end
      case ({accept, commit_now})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Retirement outputs: strobes pulse for one cycle, data fields hold.
  always_comb begin
    commit_valid_d  = commit_now;
    commit_wen_d    = commit_now && (head_func <= F_LOAD);
    commit_mem_we_d = commit_now && (head_func == F_STORE);
    flush_d         = flush_now;
    commit_tag_d    = commit_tag_q;
    commit_rd_d     = commit_rd_q;
    commit_data_d   = commit_data_q;
    commit_addr_d   = commit_addr_q;
    if (commit_now) begin
      commit_tag_d  = head_q;
      commit_rd_d   = rd_q[head_q];
      commit_data_d = data_q[head_q];
      commit_addr_d = addr_q[head_q];
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      valid_q         <= '0;
      done_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_valid_q  <= 1'b0;
      commit_tag_q    <= '0;
      commit_wen_q    <= 1'b0;
      commit_rd_q     <= '0;
      commit_data_q   <= '0;
      commit_mem_we_q <= 1'b0;
      commit_addr_q   <= '0;
      flush_q         <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      done_q          <= done_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_valid_q  <= commit_valid_d;
      commit_tag_q    <= commit_tag_d;
      commit_wen_q    <= commit_wen_d;
      commit_rd_q     <= commit_rd_d;
      commit_data_q   <= commit_data_d;
      commit_mem_we_q <= commit_mem_we_d;
      commit_addr_q   <= commit_addr_d;
      flush_q         <= flush_d;
    end
  end

  always_ff @(posedge clk1) begin
    taken_q <= taken_d;
    func_q  <= func_d;
    rd_q    <= rd_d;
    data_q  <= data_d;
    addr_q  <= addr_d;
  end

  assign commit_valid  = commit_valid_q;
  assign commit_tag    = commit_tag_q;
  assign commit_wen    = commit_wen_q;
  assign commit_rd     = commit_rd_q;
  assign commit_data   = commit_data_q;
  assign commit_mem_we = commit_mem_we_q;
  assign commit_addr   = commit_addr_q;
  assign flush         = flush_q;

endmodule

// File: tb/tb_rob_commit.sv
// Testbench for rob_commit: directed vector table, a full/wrap sequence and
// randomized traffic, all checked against a queue-based reference model.
module tb_rob_commit;

  // ---------------- clock / reset ----------------
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  logic        alloc_valid = 1'b0;
  logic [3:0]  alloc_func  = '0;
  logic [3:0]  alloc_rd    = '0;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        wb_valid    = 1'b0;
  logic [2:0]  wb_tag      = '0;
  logic [15:0] wb_data     = '0;
  logic [7:0]  wb_addr     = '0;
  logic        wb_taken    = 1'b0;
  logic        commit_valid;
  logic [2:0]  commit_tag;
  logic        commit_wen;
  logic [3:0]  commit_rd;
  logic [15:0] commit_data;
  logic        commit_mem_we;
  logic [7:0]  commit_addr;
  logic        flush;

  rob_commit #(.DEPTH(8), .DW(16)) dut (
    .clk1(clk1), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_addr(wb_addr), .wb_taken(wb_taken),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_wen(commit_wen), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_mem_we(commit_mem_we), .commit_addr(commit_addr), .flush(flush)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The ROB is modelled as an ordered list of in-flight instructions.
  typedef struct {
    logic [2:0]  tag;
    logic [3:0]  func;
    logic [3:0]  rd;
    bit          done;
    logic [15:0] data;
    logic [7:0]  addr;
    bit          taken;
  } ent_t;

  ent_t mq[$];
  int   m_head = 0;
  bit   e_cv, e_wen, e_mwe, e_fl;
  // Scoreboard of retirements: {tag, rd, data, addr}.
  logic [30:0] exp_q[$];

  function automatic bit is_br(input logic [3:0] f);
    return (f == 4'd6) || (f == 4'd7);
  endfunction

  function automatic bit m_flush_now();
    return (mq.size() > 0) && mq[0].done && is_br(mq[0].func) && mq[0].taken;
  endfunction

  function automatic bit m_ready();
    return (mq.size() < 8) && !m_flush_now();
  endfunction

  function automatic logic [2:0] m_tail();
    return 3'((m_head + mq.size()) % 8);
  endfunction

  task automatic model_step(input logic rs, input logic av, input logic [3:0] f,
                            input logic [3:0] rd, input logic wv, input logic [2:0] wt,
                            input logic [15:0] wd, input logic [7:0] wa, input logic tk);
    bit   acc, com, fl;
    ent_t h;
    ent_t n;
    logic [2:0] t;
    if (rs) begin
      mq.delete();
      exp_q.delete();
      m_head = 0;
      e_cv = 0; e_wen = 0; e_mwe = 0; e_fl = 0;
      return;
    end
    acc = av && m_ready();
    t   = m_tail();
    com = (mq.size() > 0) && mq[0].done;
    fl  = m_flush_now();
    if (com) h = mq[0];
    if (wv) begin
      foreach (mq[i]) begin
        if (mq[i].tag == wt) begin
          mq[i].done = 1; mq[i].data = wd; mq[i].addr = wa; mq[i].taken = tk;
        end
      end
    end
    e_cv = com;
    e_wen = com && (h.func <= 4'd4);
    e_mwe = com && (h.func == 4'd5);
    e_fl = fl;
    if (com) begin
      exp_q.push_back({h.tag, h.rd, h.data, h.addr});
      void'(mq.pop_front());
      m_head = (m_head + 1) % 8;
    end
    if (fl) mq.delete();
    else if (acc) begin
      n.tag = t; n.func = f; n.rd = rd; n.done = 0;
      n.data = '0; n.addr = '0; n.taken = 0;
      mq.push_back(n);
    end
  endtask

  // ---------------- driver ----------------
  logic       s_rdy;
  logic [2:0] s_atag;

  task automatic cycle(input logic rs, input logic av, input logic [3:0] f,
                       input logic [3:0] rd, input logic wv, input logic [2:0] wt,
                       input logic [15:0] wd, input logic [7:0] wa, input logic tk);
    logic [30:0] rec;
    @(negedge clk1);
    rst = rs; alloc_valid = av; alloc_func = f; alloc_rd = rd;
    wb_valid = wv; wb_tag = wt; wb_data = wd; wb_addr = wa; wb_taken = tk;
    #1;
    s_rdy = alloc_ready;
    s_atag = alloc_tag;
    if (!rs) begin
      check("m_alloc_ready", 32'(alloc_ready), 32'(m_ready()));
      check("m_alloc_tag", 32'(alloc_tag), 32'(m_tail()));
    end
    @(posedge clk1);
    model_step(rs, av, f, rd, wv, wt, wd, wa, tk);
    #1;
    check("m_commit_valid", 32'(commit_valid), 32'(e_cv));
    check("m_commit_wen", 32'(commit_wen), 32'(e_wen));
    check("m_commit_mem_we", 32'(commit_mem_we), 32'(e_mwe));
    check("m_flush", 32'(flush), 32'(e_fl));
    if (rs) begin
      check("rst_commit_data", 32'(commit_data), 32'd0);
      check("rst_commit_tag", 32'(commit_tag), 32'd0);
      check("rst_commit_addr", 32'(commit_addr), 32'd0);
    end
    if (e_cv && exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      check("m_commit_tag", 32'(commit_tag), 32'(rec[30:28]));
      if (e_wen) begin
        check("m_commit_rd", 32'(commit_rd), 32'(rec[27:24]));
        check("m_commit_data", 32'(commit_data), 32'(rec[23:8]));
      end
      if (e_mwe) begin
        check("m_store_data", 32'(commit_data), 32'(rec[23:8]));
        check("m_commit_addr", 32'(commit_addr), 32'(rec[7:0]));
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rs; logic av; logic [3:0] f; logic [3:0] rd;
    logic wv; logic [2:0] wt; logic [15:0] wd; logic [7:0] wa; logic tk;
    logic rdy; logic [2:0] atag;
    logic cv; logic wen; logic mwe; logic fl;
    logic [2:0] ctag; logic [3:0] crd; logic [15:0] cdata; logic [7:0] caddr;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic rs, input logic av, input logic [3:0] f,
                         input logic [3:0] rd, input logic wv, input logic [2:0] wt,
                         input logic [15:0] wd, input logic [7:0] wa, input logic tk,
                         input logic rdy, input logic [2:0] atag,
                         input logic cv, input logic wen, input logic mwe, input logic fl,
                         input logic [2:0] ctag, input logic [3:0] crd,
                         input logic [15:0] cdata, input logic [7:0] caddr);
    vec_t v;
    v.rs = rs; v.av = av; v.f = f; v.rd = rd; v.wv = wv; v.wt = wt;
    v.wd = wd; v.wa = wa; v.tk = tk; v.rdy = rdy; v.atag = atag;
    v.cv = cv; v.wen = wen; v.mwe = mwe; v.fl = fl;
    v.ctag = ctag; v.crd = crd; v.cdata = cdata; v.caddr = caddr;
    tbl.push_back(v);
  endtask

  initial begin
    // rs av f rd wv wt wd wa tk | rdy atag | cv wen mwe fl ctag crd cdata caddr
    // add rd=3, writeback, commit next cycle
    add_row(1,0,0,0, 0,0,0,0,0,       0,0, 0,0,0,0, 0,0,0,0);
    add_row(0,1,0,3, 0,0,0,0,0,       1,0, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 1,0,16'h00AB,0,0, 1,1, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 0,0,0,0,0,       1,1, 1,1,0,0, 0,3,16'h00AB,0);
    add_row(0,0,0,0, 0,0,0,0,0,       1,1, 0,0,0,0, 0,0,0,0);
    // store
    add_row(1,0,0,0, 0,0,0,0,0,       0,0, 0,0,0,0, 0,0,0,0);
    add_row(0,1,5,0, 0,0,0,0,0,       1,0, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 1,0,16'h1234,8'h40,0, 1,1, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 0,0,0,0,0,       1,1, 1,0,1,0, 0,0,16'h1234,8'h40);
    // out-of-order completion, in-order retirement
    add_row(1,0,0,0, 0,0,0,0,0,       0,0, 0,0,0,0, 0,0,0,0);
    add_row(0,1,0,1, 0,0,0,0,0,       1,0, 0,0,0,0, 0,0,0,0);
    add_row(0,1,1,2, 0,0,0,0,0,       1,1, 0,0,0,0, 0,0,0,0);
    add_row(0,1,2,3, 0,0,0,0,0,       1,2, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 1,2,16'h22,0,0,  1,3, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 1,1,16'h11,0,0,  1,3, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 1,0,16'h10,0,0,  1,3, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 0,0,0,0,0,       1,3, 1,1,0,0, 0,1,16'h10,0);
    add_row(0,0,0,0, 0,0,0,0,0,       1,3, 1,1,0,0, 1,2,16'h11,0);
    add_row(0,0,0,0, 0,0,0,0,0,       1,3, 1,1,0,0, 2,3,16'h22,0);
    add_row(0,0,0,0, 0,0,0,0,0,       1,3, 0,0,0,0, 0,0,0,0);
    // taken beq flushes the younger add
    add_row(1,0,0,0, 0,0,0,0,0,       0,0, 0,0,0,0, 0,0,0,0);
    add_row(0,1,6,0, 0,0,0,0,0,       1,0, 0,0,0,0, 0,0,0,0);
    add_row(0,1,0,5, 0,0,0,0,0,       1,1, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 1,1,16'h55,0,0,  1,2, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 1,0,16'h0,0,1,   1,2, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 0,0,0,0,0,       0,2, 1,0,0,1, 0,0,0,0);
    add_row(0,0,0,0, 0,0,0,0,0,       1,1, 0,0,0,0, 0,0,0,0);
    add_row(0,1,0,7, 0,0,0,0,0,       1,1, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 1,1,16'h77,0,0,  1,2, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 0,0,0,0,0,       1,2, 1,1,0,0, 1,7,16'h77,0);
    // reset with four live entries, head already complete
    add_row(1,0,0,0, 0,0,0,0,0,       0,0, 0,0,0,0, 0,0,0,0);
    add_row(0,1,0,1, 0,0,0,0,0,       1,0, 0,0,0,0, 0,0,0,0);
    add_row(0,1,0,2, 0,0,0,0,0,       1,1, 0,0,0,0, 0,0,0,0);
    add_row(0,1,0,3, 0,0,0,0,0,       1,2, 0,0,0,0, 0,0,0,0);
    add_row(0,1,0,4, 0,0,0,0,0,       1,3, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 1,0,16'h99,0,0,  1,4, 0,0,0,0, 0,0,0,0);
    add_row(1,0,0,0, 0,0,0,0,0,       0,0, 0,0,0,0, 0,0,0,0);
    add_row(0,0,0,0, 0,0,0,0,0,       1,0, 0,0,0,0, 0,0,0,0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rs, tbl[i].av, tbl[i].f, tbl[i].rd, tbl[i].wv, tbl[i].wt,
            tbl[i].wd, tbl[i].wa, tbl[i].tk);
      if (!tbl[i].rs) begin
        check("v_alloc_ready", 32'(s_rdy), 32'(tbl[i].rdy));
        check("v_alloc_tag", 32'(s_atag), 32'(tbl[i].atag));
      end
      check("v_commit_valid", 32'(commit_valid), 32'(tbl[i].cv));
      check("v_commit_wen", 32'(commit_wen), 32'(tbl[i].wen));
      check("v_commit_mem_we", 32'(commit_mem_we), 32'(tbl[i].mwe));
      check("v_flush", 32'(flush), 32'(tbl[i].fl));
      if (tbl[i].cv) check("v_commit_tag", 32'(commit_tag), 32'(tbl[i].ctag));
      if (tbl[i].wen) begin
        check("v_commit_rd", 32'(commit_rd), 32'(tbl[i].crd));
        check("v_commit_data", 32'(commit_data), 32'(tbl[i].cdata));
      end
      if (tbl[i].mwe) begin
        check("v_store_data", 32'(commit_data), 32'(tbl[i].cdata));
        check("v_commit_addr", 32'(commit_addr), 32'(tbl[i].caddr));
      end
    end

    // ---------------- full ROB, no bypass, pointer wrap ----------------
    cycle(1,0,0,0, 0,0,0,0,0);
    for (int i = 0; i < 8; i++) begin
      cycle(0,1,4'd0,4'(i), 0,0,0,0,0);
      check("full_fill_ready", 32'(s_rdy), 32'd1);
      check("full_fill_tag", 32'(s_atag), 32'(i));
    end
    cycle(0,1,4'd1,4'd9, 1,3'd0,16'h0F0F,0,0);
    check("full_ready", 32'(s_rdy), 32'd0);
    cycle(0,1,4'd1,4'd9, 0,0,0,0,0);
    check("full_no_bypass", 32'(s_rdy), 32'd0);
    check("full_commit", 32'(commit_valid), 32'd1);
    cycle(0,0,0,0, 0,0,0,0,0);
    check("wrap_ready", 32'(s_rdy), 32'd1);
    check("wrap_tag", 32'(s_atag), 32'd0);

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 1500; n++) begin
      logic rs, av, wv, tk;
      logic [3:0] f, rd;
      logic [2:0] wt;
      rs = ($urandom_range(0, 99) == 0);
      av = ($urandom_range(0, 9) < 7);
      f  = 4'($urandom_range(0, 7));
      rd = 4'($urandom_range(0, 15));
      wv = ($urandom_range(0, 9) < 6);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0)
        wt = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        wt = 3'($urandom_range(0, 7));
      tk = ($urandom_range(0, 3) == 0);
      cycle(rs, av, f, rd, wv, wt, 16'($urandom), 8'($urandom), tk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
